// File: rtl/adder_tree_seq_scheduler.sv
// Sequential replacement for a parallel adder tree: one operand vector is accepted,
// reduced on a single shared adder (one addition per cycle) and returned as one sum.
module adder_tree_seq_scheduler #(
    parameter int ADDER_WIDTH  = 22,
    parameter int NUM_OPERANDS = 8,
    parameter int LOG2N        = $clog2(NUM_OPERANDS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_OPERANDS*ADDER_WIDTH-1:0]   in_ops,
    input  logic                                  flush,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ADDER_WIDTH+LOG2N-1:0]          sum,
    output logic                                  busy,
    output logic [1:0]                            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // valid/data stay stable until the transfer, ready never depends on valid.

    localparam int SW = ADDER_WIDTH + LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NUM_OPERANDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                               state_q;
    logic [SW-1:0]                        acc_q;
    logic [SW-1:0]                        sum_q;
    logic [LOG2N-1:0]                     idx_q;
    logic [NUM_OPERANDS*ADDER_WIDTH-1:0]  ops_q;
    logic                                 in_ready_q;
    logic                                 out_valid_q;
    logic                                 busy_q;

    logic [ADDER_WIDTH-1:0]               op_sel;
    logic [SW-1:0]                        acc_d;

    // The single shared adder: accumulator plus the operand selected by idx.
    assign op_sel = ops_q[int'(idx_q)*ADDER_WIDTH +: ADDER_WIDTH];
    assign acc_d  = acc_q + {{LOG2N{1'b0}}, op_sel};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            ops_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            // Abort wins over both accept and the output handshake.
            state_q     <= IDLE;
            acc_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        ops_q      <= in_ops;
                        acc_q      <= {{LOG2N{1'b0}}, in_ops[ADDER_WIDTH-1:0]};
                        idx_q      <= LOG2N'(1);
                        state_q    <= ADD;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ADD: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        sum_q       <= acc_d;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        sum_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    sum_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_tree_seq_scheduler.sv
// Directed bench for adder_tree_seq_scheduler: a vector table of full jobs plus
// hand-written sequences for stall, back-to-back, reset and flush corner cases.
module tb_adder_tree_seq_scheduler;

    localparam int W   = 22;
    localparam int N   = 8;
    localparam int SW  = 25;
    localparam int LAT = 7;
    localparam int MAXW = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N*W-1:0] in_ops;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] sum;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    logic [SW-1:0] exp_q[$];

    typedef struct {
        string          name;
        logic [N*W-1:0] ops;
        logic [SW-1:0]  exp_sum;
    } vec_t;

    vec_t vecs[7];

    adder_tree_seq_scheduler #(
        .ADDER_WIDTH (W),
        .NUM_OPERANDS(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ops   (in_ops),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [N*W-1:0] pack8(input logic [W-1:0] a0, a1, a2, a3,
                                             input logic [W-1:0] a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_out_valid(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < MAXW) begin
            tick();
            edges++;
        end
    endtask

    task automatic start_job(input logic [N*W-1:0] ops);
        in_ops   = ops;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_job(input string name, input logic [N*W-1:0] ops,
                           input logic [SW-1:0] exp_sum);
        int e;
        logic [SW-1:0] exp_v;
        chk({name, "_in_ready_before"}, 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        start_job(ops);
        exp_q.push_back(exp_sum);
        wait_out_valid(e);
        chk({name, "_latency"}, 32'(e), 32'(LAT));
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({name, "_sum"}, 32'(sum), 32'(exp_v));
        tick();
        chk({name, "_out_valid_one_cycle"}, 32'(out_valid), 32'd0);
        chk({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int e;
        int seen;

        vecs[0] = '{"seq_1_to_8", pack8(1, 2, 3, 4, 5, 6, 7, 8), 25'd36};
        vecs[1] = '{"all_max", pack8(22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF,
                                     22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF),
                    25'h1FFFFF8};
        vecs[2] = '{"all_zero", pack8(0, 0, 0, 0, 0, 0, 0, 0), 25'd0};
        vecs[3] = '{"last_only", pack8(0, 0, 0, 0, 0, 0, 0, 22'h3FFFFF), 25'h3FFFFF};
        vecs[4] = '{"first_only", pack8(22'h123456, 0, 0, 0, 0, 0, 0, 0), 25'h123456};
        vecs[5] = '{"pow2_x8", pack8(22'h100000, 22'h100000, 22'h100000, 22'h100000,
                                     22'h100000, 22'h100000, 22'h100000, 22'h100000),
                    25'h800000};
        vecs[6] = '{"carry_out_22", pack8(22'h3FFFFF, 1, 0, 0, 0, 0, 0, 0), 25'h400000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ops    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state, during and after reset
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_state", 32'(dbg_state), 32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Table-driven full jobs
        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].name, vecs[i].ops, vecs[i].exp_sum);
        end

        // Output stall in DONE, in_valid ignored while busy
        out_ready = 1'b0;
        start_job(pack8(10, 20, 30, 40, 50, 60, 70, 80));
        wait_out_valid(e);
        chk("stall_latency", 32'(e), 32'(LAT));
        in_valid = 1'b1;
        in_ops   = pack8(1, 1, 1, 1, 1, 1, 1, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'd360);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_ops    = pack8(1, 2, 3, 4, 5, 6, 7, 8);
        out_ready = 1'b1;
        tick();
        chk("stall_release_out_valid", 32'(out_valid), 32'd0);
        chk("stall_release_sum", 32'(sum), 32'd0);
        chk("stall_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("stall_next_accept_busy", 32'(busy), 32'd1);
        wait_out_valid(e);
        chk("stall_next_latency", 32'(e), 32'(LAT));
        chk("stall_next_sum", 32'(sum), 32'd36);
        tick();

        // Back-to-back: in_valid held, operands change after accept
        out_ready = 1'b1;
        in_ops    = pack8(1, 2, 3, 4, 5, 6, 7, 8);
        in_valid  = 1'b1;
        tick();
        in_ops = pack8(100, 100, 100, 100, 100, 100, 100, 100);
        wait_out_valid(e);
        chk("b2b_first_latency", 32'(e), 32'(LAT));
        chk("b2b_first_sum", 32'(sum), 32'd36);
        tick();
        chk("b2b_gap_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_gap_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        chk("b2b_second_in_ready", 32'(in_ready), 32'd0);
        wait_out_valid(e);
        chk("b2b_second_latency", 32'(e), 32'(LAT));
        chk("b2b_second_sum", 32'(sum), 32'd800);
        tick();

        // Asynchronous reset after three adds
        start_job(pack8(1, 2, 3, 4, 5, 6, 7, 8));
        tick();
        tick();
        tick();
        chk("mid_add_state", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(dbg_state), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        chk("rst_job_dropped", 32'(seen), 32'd0);
        run_job("after_rst", vecs[5].ops, vecs[5].exp_sum);

        // Flush in ADD
        start_job(pack8(1, 2, 3, 4, 5, 6, 7, 8));
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_add_in_ready", 32'(in_ready), 32'd1);
        chk("flush_add_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        chk("flush_add_no_result", 32'(seen), 32'd0);

        // Flush beats accept in IDLE
        in_ops   = pack8(9, 9, 9, 9, 9, 9, 9, 9);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_idle_state", 32'(dbg_state), 32'd0);
        chk("flush_idle_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        chk("flush_idle_no_result", 32'(seen), 32'd0);

        // Flush beats the output handshake in DONE
        out_ready = 1'b0;
        start_job(pack8(1, 2, 3, 4, 5, 6, 7, 8));
        wait_out_valid(e);
        chk("flush_done_latency", 32'(e), 32'(LAT));
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_done_out_valid", 32'(out_valid), 32'd0);
        chk("flush_done_sum", 32'(sum), 32'd0);
        chk("flush_done_in_ready", 32'(in_ready), 32'd1);

        run_job("after_flush", vecs[0].ops, vecs[0].exp_sum);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
